// File: rtl/div_pkg.sv
// Shared widths and FSM state type for the seq_div32 restoring divider.
package div_pkg;
  localparam int DIVIDEND_W = 32;
  localparam int DIVISOR_W  = 16;
  localparam int CNT_W      = 6;
  localparam int ITER       = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract.
module div_step
  import div_pkg::*;
(
  input  logic [DIVISOR_W-1:0] pr,
  input  logic                 din,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   pr_nxt,
  output logic                 qbit
);
  logic [DIVISOR_W:0] t;
  logic [DIVISOR_W:0] dvs_ext;

  assign t       = {pr, din};
  assign dvs_ext = {1'b0, divisor};

  always_comb begin
    qbit   = (t >= dvs_ext);
    pr_nxt = qbit ? (t - dvs_ext) : t;
  end
endmodule

// File: rtl/seq_div32.sv
// Sequential 32/16 unsigned restoring divider, one quotient bit per clock.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips RUN and finishes in one cycle.
module seq_div32
  import div_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  dz
);
  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [DIVIDEND_W-1:0] dq;
  logic [DIVIDEND_W-1:0] qsr;
  logic [DIVISOR_W-1:0]  dvs;
  logic [DIVISOR_W:0]    pr;
  logic [DIVISOR_W:0]    pr_nxt;
  logic                  qbit;
  logic                  fast_zero;
  logic                  pr_msb_unused;

  // The restoring invariant keeps pr below the divisor, so its top bit is always clear.
  assign pr_msb_unused = pr[DIVISOR_W] ^ pr_nxt[DIVISOR_W];

`ifdef DIV_ZERO_FAST_EN
  assign fast_zero = (divisor == '0);
`else
  assign fast_zero = 1'b0;
`endif

  div_step u_step (
    .pr      (pr[DIVISOR_W-1:0]),
    .din     (dq[DIVIDEND_W-1]),
    .divisor (dvs),
    .pr_nxt  (pr_nxt),
    .qbit    (qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      dz        <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start && fast_zero) begin
            state     <= DONE;
            done      <= 1'b1;
            quotient  <= '1;
            remainder <= dividend[DIVISOR_W-1:0];
            dz        <= 1'b1;
          end else if (start) begin
            dq    <= dividend;
            dvs   <= divisor;
            pr    <= '0;
            qsr   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          pr  <= pr_nxt;
          dq  <= {dq[DIVIDEND_W-2:0], 1'b0};
          qsr <= {qsr[DIVIDEND_W-2:0], qbit};
          cnt <= cnt + 1'b1;
          // Results land on the same edge that enters DONE.
          if (cnt == CNT_W'(ITER - 1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= {qsr[DIVIDEND_W-2:0], qbit};
            remainder <= pr_nxt[DIVISOR_W-1:0];
            dz        <= (dvs == '0);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_div32.sv
// Randomised self-checking bench for seq_div32 against an arithmetic reference model.
module tb_seq_div32;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        dz;

  int n_vec = 0;
  int n_err = 0;

`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  seq_div32 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] ref_div(input logic [31:0] a, input logic [15:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 16'd0) return {32'hFFFF_FFFF, a[15:0]};
    q = a / {16'd0, b};
    r = a % {16'd0, b};
    return {q, r[15:0]};
  endfunction

  // Called at a falling edge; the next rising edge accepts the operands.
  task automatic launch(input logic [31:0] a, input logic [15:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the falling edge of cycle t+1; returns at the falling edge of the done cycle.
  task automatic wait_check(input string tag, input logic [31:0] a, input logic [15:0] b,
                            input bit noisy);
    int          lat;
    int          busy_n;
    bit          got;
    logic [47:0] exp;
    lat    = 1;
    busy_n = 0;
    got    = 1'b0;
    exp    = ref_div(a, b);
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) busy_n++;
      if (noisy) begin
        start    = 1'b1;
        dividend = $urandom;
        divisor  = 16'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, "_latency"}, 32'(lat), (FAST && b == 16'd0) ? 32'd1 : 32'd33);
      check({tag, "_busy_cycles"}, 32'(busy_n), (FAST && b == 16'd0) ? 32'd0 : 32'd32);
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      check({tag, "_quotient"}, quotient, exp[47:16]);
      check({tag, "_remainder"}, 32'(remainder), 32'(exp[15:0]));
      check({tag, "_dz"}, 32'(dz), 32'(b == 16'd0));
    end
  endtask

  task automatic op(input string tag, input logic [31:0] a, input logic [15:0] b,
                    input bit noisy);
    launch(a, b);
    wait_check(tag, a, b, noisy);
  endtask

  initial begin
    logic [31:0] a;
    logic [15:0] b;
    logic [47:0] exp;
    int          dcount;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dz", 32'(dz), 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    op("d100_7", 32'd100, 16'd7, 1'b0);
    check("d100_7_const_q", quotient, 32'd14);
    check("d100_7_const_r", 32'(remainder), 32'd2);
    @(negedge clk);
    op("dmax", 32'hFFFF_FFFF, 16'hFFFF, 1'b0);
    check("dmax_const_q", quotient, 32'h0001_0001);
    op("d1234", 32'h1234_5678, 16'h1234, 1'b0);

    // Back-to-back: second start issued during the done cycle.
    op("d5_9", 32'd5, 16'd9, 1'b0);
    op("d9_5", 32'd9, 16'd5, 1'b0);
    check("d9_5_const_q", quotient, 32'd1);
    check("d9_5_const_r", 32'(remainder), 32'd4);

    @(negedge clk);
    op("dzero", 32'h1234_5678, 16'd0, 1'b0);
    check("dzero_const_r", 32'(remainder), 32'h5678);
    @(negedge clk);
    op("zero_dvd", 32'd0, 16'd1, 1'b0);
    op("noisy", 32'hDEAD_BEEF, 16'd77, 1'b1);

    // Reset mid-operation discards the result and clears outputs.
    @(negedge clk);
    launch(32'd1000, 16'd3);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_quotient", quotient, 32'd0);
    check("midrst_remainder", 32'(remainder), 32'd0);
    check("midrst_dz", 32'(dz), 32'd0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check("midrst_quiet", 32'(dcount), 32'd0);
    op("d1000_3", 32'd1000, 16'd3, 1'b0);
    check("d1000_3_const_q", quotient, 32'd333);

    for (int k = 0; k < 150; k++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 16'd0;
        1:       b = 16'($urandom_range(1, 15));
        2:       b = 16'hFFFF;
        default: b = 16'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) a = {16'd0, a[15:0]};
      op("rand", a, b, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 4)) @(negedge clk);
        exp = ref_div(a, b);
        check("rand_hold_q", quotient, exp[47:16]);
        check("rand_hold_r", 32'(remainder), 32'(exp[15:0]));
        check("rand_hold_done", 32'(done), 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
